// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: width, funct3 codes,
// sequencer states and operand-signedness helpers.
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // {rs1 signed, rs2 signed}
  function automatic logic [1:0] is_signed(input logic [2:0] op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 2'b11;
      OP_MULHSU:               return 2'b10;
      default:                 return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; with neg tied to the sign bit it yields
// the absolute value.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M executor: shift-add multiplier and restoring divider sharing
// one 32-step sequencer; divide-by-zero and signed overflow bypass the loop.
module mul_div_unit #(
  parameter int XLEN  = mdu_pkg::XLEN,
  parameter int ITERS = XLEN
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      ALU_OP,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);
  import mdu_pkg::*;

  state_t            state, state_nxt;
  logic [2:0]        op_r;
  logic              neg1_r, neg2_r, special_r;
  logic [5:0]        cnt;
  logic [XLEN-1:0]   mcand_r, spec_res_r, result_r;
  logic [2*XLEN-1:0] acc, acc_step;

  logic              sgn1, sgn2, div_zero, div_ovf, special;
  logic [XLEN-1:0]   abs1, abs2, spec_val, fin_result;

  assign sgn1 = is_signed(ALU_OP)[1] & OPERAND1[XLEN-1];
  assign sgn2 = is_signed(ALU_OP)[0] & OPERAND2[XLEN-1];

  mdu_sign_fix #(.W(XLEN)) u_abs1 (.value(OPERAND1), .neg(sgn1), .result(abs1));
  mdu_sign_fix #(.W(XLEN)) u_abs2 (.value(OPERAND2), .neg(sgn2), .result(abs2));

  assign div_zero = is_div(ALU_OP) && (OPERAND2 == '0);
  assign div_ovf  = is_div(ALU_OP) && !ALU_OP[0]
                    && (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) && (OPERAND2 == '1);
  assign special  = div_zero | div_ovf;

  // ALU_OP[1] distinguishes REM* from DIV* within the divide group
  always_comb begin
    spec_val = '0;
    if (div_zero)
      spec_val = ALU_OP[1] ? OPERAND1 : '1;
    else if (!ALU_OP[1])
      spec_val = {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration: acc holds {hi, multiplier} for mul, {remainder, quotient} for div
  logic [XLEN:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand_r} : '0);
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mcand_r};

  always_comb begin
    if (is_div(op_r))
      acc_step = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  mdu_sign_fix #(.W(2*XLEN)) u_fix_prod (.value(acc), .neg(neg1_r ^ neg2_r), .result(prod_fix));
  mdu_sign_fix #(.W(XLEN)) u_fix_quo (.value(acc[XLEN-1:0]), .neg(neg1_r ^ neg2_r), .result(quo_fix));
  mdu_sign_fix #(.W(XLEN)) u_fix_rem (.value(acc[2*XLEN-1:XLEN]), .neg(neg1_r), .result(rem_fix));

  always_comb begin
    fin_result = prod_fix[2*XLEN-1:XLEN];
    if (special_r)
      fin_result = spec_res_r;
    else begin
      case (op_r)
        OP_MUL:          fin_result = prod_fix[XLEN-1:0];
        OP_DIV, OP_DIVU: fin_result = quo_fix;
        OP_REM, OP_REMU: fin_result = rem_fix;
        default:         fin_result = prod_fix[2*XLEN-1:XLEN];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    RESULT    = result_r;
    case (state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) state_nxt = special ? ST_FIN : ST_CALC;
      end
      ST_CALC: if (cnt == 6'(ITERS-1)) state_nxt = ST_FIN;
      ST_FIN: begin
        DONE      = 1'b1;
        RESULT    = fin_result;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_r       <= '0;
      neg1_r     <= 1'b0;
      neg2_r     <= 1'b0;
      special_r  <= 1'b0;
      cnt        <= '0;
      mcand_r    <= '0;
      spec_res_r <= '0;
      result_r   <= '0;
      acc        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (START) begin
          op_r       <= ALU_OP;
          neg1_r     <= sgn1;
          neg2_r     <= sgn2;
          special_r  <= special;
          spec_res_r <= spec_val;
          cnt        <= '0;
          mcand_r    <= is_div(ALU_OP) ? abs2 : abs1;
          acc        <= {{XLEN{1'b0}}, is_div(ALU_OP) ? abs1 : abs2};
        end
        ST_CALC: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
        end
        ST_FIN:  result_r <= fin_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed self-check of mul_div_unit against an arithmetic
// reference model with a per-cycle BUSY/DONE/RESULT scoreboard.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  typedef struct {
    int          start_cyc;
    int          lat;
    logic [31:0] res;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_result = '0;

  mul_div_unit dut (
    .CLK(clk), .RESET(rst), .START(start), .ALU_OP(op),
    .OPERAND1(a), .OPERAND2(b), .BUSY(busy), .DONE(done), .RESULT(result)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, uy;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    uy = {32'b0, y};
    case (o)
      OP_MUL:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      OP_MULH:   begin p = sx * sy;                 return p[63:32]; end
      OP_MULHSU: begin p = sx * uy;                 return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      OP_DIV:    begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = sx / sy;
        return p[31:0];
      end
      OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM:    begin
        if (y == 0) return x;
        p = sx % sy;
        return p[31:0];
      end
      default:   return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Per-cycle scoreboard against the front of the expectation queue
  always @(negedge clk) begin : chk
    logic eb, ed;
    if (chk_en) begin
      eb = 1'b0;
      ed = 1'b0;
      if (q.size() > 0) begin
        eb = (cyc > q[0].start_cyc) && (cyc <= q[0].start_cyc + q[0].lat);
        ed = (cyc == q[0].start_cyc + q[0].lat);
      end
      check("busy", {31'b0, busy}, {31'b0, eb});
      check("done", {31'b0, done}, {31'b0, ed});
      if (ed) begin
        check("result", result, q[0].res);
        last_result = q[0].res;
        void'(q.pop_front());
      end else if (q.size() == 0) begin
        check("held_result", result, last_result);
      end
    end
  end

  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    e.start_cyc = cyc;
    e.lat = is_special(o, x, y) ? 1 : 33;
    e.res = ref_op(o, x, y);
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: DONE not seen within 40 cycles");
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] lit);
    check({"model_", name}, ref_op(o, x, y), lit);
    start_op(o, x, y);
    wait_done();
    check(name, result, lit);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);

    run("mul",      OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulh",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("div",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run("rem",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run("divu",     OP_DIVU,   32'd100,       32'd7,         32'd14);
    run("remu",     OP_REMU,   32'd100,       32'd7,         32'd2);
    run("div_zero", OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF);
    run("remu_zero", OP_REMU,  32'd5,         32'd0,         32'd5);
    run("div_ovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run("mul_zero", OP_MUL,    32'd0,         32'h1234_5678, 32'd0);

    // START during CALC must be dropped
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    check("ignored_start", result, 32'd333);

    // Reset in the middle of an operation
    start_op(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    last_result = '0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge clk);
    run("after_rst", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);

    for (int i = 0; i < 320; i++) begin
      start_op(3'(i % 8), pick(), pick());
      wait_done();
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
